// File: rtl/act_relay_pkg.sv
// ============================================================================
// act_relay_pkg : shared state type and sizing constants for act_relay
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package act_relay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam int DEFAULT_DEPTH = 128;

  // Counter width able to hold 0..depth inclusive
  function automatic int ptr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W = ptr_w(DEFAULT_DEPTH);

endpackage

`default_nettype wire

// File: rtl/act_relay_mem.sv
// ============================================================================
// act_relay_mem : simple dual-port activation buffer, registered read port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module act_relay_mem
  import act_relay_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register returns zero on idle cycles so it can drive the bus directly
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/act_relay.sv
// ============================================================================
// act_relay : buffers one layer of activations, then broadcasts them to a MAC
//             array and signals completion. Macro ACT_RELAY_RELU_EN clamps
//             negative inputs to zero on write.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module act_relay
  import act_relay_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FLUSH_CYC  = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_done_i,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_mac_en_o,
  output logic                  out_relu_en_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int CNT_W = ptr_w(DEPTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(DEPTH);
  localparam logic [FW-1:0]    C_FLUSH_LAST = FW'(FLUSH_CYC);

  state_t                r_state;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [AW-1:0]         r_rd_ptr;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_mac_en;
  logic                  r_relu_en;
  logic                  r_err;

  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_last_rd;
  logic                  w_stray;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd_data;

`ifdef ACT_RELAY_RELU_EN
  assign w_wr_data = in_data_i[DATA_WIDTH-1] ? '0 : in_data_i;
`else
  assign w_wr_data = in_data_i;
`endif

  assign w_full    = (r_wr_cnt == C_DEPTH);
  assign w_wr_en   = in_valid_i && !w_full &&
                     ((r_state == ST_IDLE) || (r_state == ST_FILL));
  assign w_rd_en   = (r_state == ST_DRAIN);
  assign w_last_rd = (CNT_W'(r_rd_ptr) == (r_wr_cnt - CNT_W'(1)));
  assign w_stray   = in_valid_i || in_done_i;

  act_relay_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_cnt[AW-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_wr_cnt    <= '0;
      r_rd_ptr    <= '0;
      r_flush_cnt <= '0;
      r_mac_en    <= 1'b0;
      r_relu_en   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_relu_en <= 1'b0;
      r_mac_en  <= w_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_wr_cnt <= CNT_W'(1);
            r_state  <= in_done_i ? ST_WAIT : ST_FILL;
          end else if (in_done_i) begin
            r_relu_en <= 1'b1;
          end
        end
        ST_FILL: begin
          if (in_valid_i) begin
            if (w_full) begin
              r_err <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
          end
          if (in_done_i) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          if (out_ready_i) begin
            r_rd_ptr <= '0;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          r_rd_ptr <= r_rd_ptr + AW'(1);
          if (w_last_rd) begin
            r_flush_cnt <= '0;
            r_state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          // Hold off completion until the consumer's accumulate pipeline empties
          if (r_flush_cnt == C_FLUSH_LAST) begin
            r_relu_en   <= 1'b1;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_flush_cnt <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data_o    = w_rd_data;
  assign out_mac_en_o  = r_mac_en;
  assign out_relu_en_o = r_relu_en;
  assign busy_o        = (r_state != ST_IDLE);
  assign err_o         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_act_relay.sv
// ============================================================================
// tb_act_relay : self-checking bench for act_relay against a queue-based model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_act_relay;

  localparam int DW        = 8;
  localparam int DEPTH     = 128;
  localparam int FLUSH_CYC = 3;
  localparam int BUDGET    = 2000;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_done_i;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_mac_en_o;
  logic          out_relu_en_o;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_err;

  act_relay #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FLUSH_CYC  (FLUSH_CYC)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_done_i     (in_done_i),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_mac_en_o  (out_mac_en_o),
    .out_relu_en_o (out_relu_en_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef ACT_RELAY_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic apply_reset();
    rstn_i      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_done_i   = 1'b0;
    out_ready_i = 1'b0;
    step();
    step();
    rstn_i  = 1'b1;
    exp_err = 1'b0;
  endtask

  // Writes stim_q, optionally with idle gaps, and builds the expected drain list
  task automatic fill(input bit done_with_last, input bit gaps);
    int n;
    n = stim_q.size();
    exp_q = {};
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      in_valid_i = 1'b1;
      in_data_i  = stim_q[i];
      in_done_i  = done_with_last && (i == n - 1);
      step();
      n_checks++;
      if (err_o !== (exp_err || (i >= DEPTH)) || busy_o !== 1'b1)
        $display("FAIL fill_write[%0d]: err=%b busy=%b, expected err=%b busy=1",
                 i, err_o, busy_o, exp_err || (i >= DEPTH));
      else n_pass++;
    end
    in_valid_i = 1'b0;
    in_done_i  = 1'b0;
    if (!done_with_last) begin
      in_done_i = 1'b1;
      step();
      in_done_i = 1'b0;
    end
    for (int i = 0; i < n && i < DEPTH; i++) exp_q.push_back(stored(stim_q[i]));
    if (n > DEPTH) exp_err = 1'b1;
  endtask

  // Releases the drain after ready_delay cycles and checks the whole output burst
  task automatic drain(input string tag, input int ready_delay, input int poke_at);
    int lat;
    int k;
    int gap;
    int bad_idx;
    bit hold_ok;
    bit idle_ok;
    bit busy_prev;
    logic [DW-1:0] got[$];

    out_ready_i = 1'b0;
    hold_ok = 1'b1;
    for (int c = 0; c < ready_delay; c++) begin
      step();
      if (out_mac_en_o !== 1'b0 || busy_o !== 1'b1) hold_ok = 1'b0;
    end
    if (ready_delay > 0) begin
      n_checks++;
      if (!hold_ok) $display("FAIL %s wait_hold: output moved while out_ready_i low", tag);
      else n_pass++;
    end

    out_ready_i = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (out_mac_en_o !== 1'b1 && lat < BUDGET);
    // one edge samples ready and enters DRAIN, the next presents element 0
    n_checks++;
    if (lat !== 2) $display("FAIL %s start_latency: got %0d cycles, expected 2", tag, lat);
    else n_pass++;

    k = 0;
    while (out_mac_en_o === 1'b1 && k < BUDGET) begin
      got.push_back(out_data_o);
      k++;
      if (k == poke_at) begin
        in_valid_i = 1'b1;
        in_data_i  = 8'h55;
        exp_err    = 1'b1;
      end
      step();
      in_valid_i  = 1'b0;
      out_ready_i = 1'($urandom_range(0, 1));
    end

    gap = 0;
    idle_ok = 1'b1;
    busy_prev = busy_o;
    while (out_relu_en_o !== 1'b1 && gap < BUDGET) begin
      if (out_data_o !== '0 || out_mac_en_o !== 1'b0) idle_ok = 1'b0;
      busy_prev = busy_o;
      gap++;
      step();
    end
    n_checks++;
    if (gap !== FLUSH_CYC || !idle_ok)
      $display("FAIL %s flush_gap: got %0d idle cycles (clean=%b), expected %0d", tag, gap, idle_ok, FLUSH_CYC);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || busy_prev !== 1'b1)
      $display("FAIL %s busy_fall: busy before=%b at relu=%b, expected 1 then 0", tag, busy_prev, busy_o);
    else n_pass++;

    n_checks++;
    if (got.size() !== exp_q.size())
      $display("FAIL %s drain_count: got %0d elements, expected %0d", tag, got.size(), exp_q.size());
    else n_pass++;
    bad_idx = -1;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad_idx < 0 && got[i] !== exp_q[i]) bad_idx = i;
    n_checks++;
    if (bad_idx >= 0)
      $display("FAIL %s drain_data[%0d]: got %h, expected %h", tag, bad_idx, got[bad_idx], exp_q[bad_idx]);
    else n_pass++;

    step();
    n_checks++;
    if (out_relu_en_o !== 1'b0 || err_o !== exp_err)
      $display("FAIL %s relu_pulse_err: relu=%b err=%b, expected relu=0 err=%b", tag, out_relu_en_o, err_o, exp_err);
    else n_pass++;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i      = 1'b0;
    in_valid_i  = 1'($urandom_range(0, 1));
    in_data_i   = DW'($urandom);
    in_done_i   = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({out_data_o, out_mac_en_o, out_relu_en_o, busy_o, err_o} !== '0)
      $display("FAIL reset_outputs: got data=%h mac=%b relu=%b busy=%b err=%b, expected all 0",
               out_data_o, out_mac_en_o, out_relu_en_o, busy_o, err_o);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_done_empty();
    in_done_i = 1'b1;
    step();
    in_done_i = 1'b0;
    n_checks++;
    if (out_relu_en_o !== 1'b1 || out_mac_en_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL done_empty_pulse: relu=%b mac=%b busy=%b, expected 1 0 0", out_relu_en_o, out_mac_en_o, busy_o);
    else n_pass++;
    step();
    n_checks++;
    if (out_relu_en_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL done_empty_after: relu=%b busy=%b, expected 0 0", out_relu_en_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_full_depth();
    stim_q = {};
    for (int i = 1; i <= DEPTH; i++) stim_q.push_back(DW'(i));
    fill(1'b0, 1'b0);
    drain("full_depth", 0, 0);
  endtask

  task automatic test_done_with_last();
    stim_q = {};
    repeat (5) stim_q.push_back(DW'($urandom));
    fill(1'b1, 1'b0);
    drain("done_with_last", 10, 0);
  endtask

  task automatic test_relu();
    stim_q = {8'hF0, 8'h10};
    fill(1'b0, 1'b0);
    drain("relu", 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++) begin
      stim_q = {};
      repeat ($urandom_range(1, DEPTH)) stim_q.push_back(DW'($urandom));
      fill(1'($urandom_range(0, 1)), 1'b1);
      drain("random_pass", $urandom_range(0, 5), 0);
    end
  endtask

  task automatic test_poke_drain();
    stim_q = {};
    repeat (20) stim_q.push_back(DW'($urandom));
    fill(1'b0, 1'b0);
    drain("poke_drain", 0, 7);
  endtask

  task automatic test_overflow();
    apply_reset();
    stim_q = {};
    for (int i = 1; i <= DEPTH + 2; i++) stim_q.push_back(DW'(i));
    fill(1'b0, 1'b0);
    drain("overflow", 2, 0);
  endtask

  task automatic test_reset_mid_drain();
    int k;
    apply_reset();
    stim_q = {};
    repeat (64) stim_q.push_back(DW'($urandom));
    fill(1'b0, 1'b0);
    out_ready_i = 1'b1;
    k = 0;
    while (k < 40 && k < BUDGET) begin
      step();
      if (out_mac_en_o === 1'b1) k++;
    end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({out_data_o, out_mac_en_o, out_relu_en_o, busy_o, err_o} !== '0)
      $display("FAIL mid_drain_reset: got data=%h mac=%b relu=%b busy=%b err=%b, expected all 0",
               out_data_o, out_mac_en_o, out_relu_en_o, busy_o, err_o);
    else n_pass++;
    out_ready_i = 1'b0;
    step();
    rstn_i  = 1'b1;
    exp_err = 1'b0;
    step();
    stim_q = {};
    repeat (3) stim_q.push_back(DW'($urandom));
    fill(1'b0, 1'b0);
    drain("after_reset", 0, 0);
  endtask

  initial begin
    exp_err = 1'b0;
    test_reset();
    test_done_empty();
    test_full_depth();
    test_done_with_last();
    test_relu();
    test_back_to_back();
    test_poke_drain();
    test_overflow();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
